// File: rtl/hash_req_arbiter_if.sv
// rtl/hash_req_arbiter_if.sv - requester and hash-core signal bundle for hash_req_arbiter
interface hash_req_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 5,
  parameter int OWN_W  = $clog2(N_REQ)
);

  // Requester side
  logic [N_REQ-1:0]      i_req_start;
  logic [32*N_REQ-1:0]   i_req_data_in;
  logic [32*N_REQ-1:0]   i_req_input_length;
  logic [32*N_REQ-1:0]   i_req_output_length;
  logic [N_REQ-1:0]      i_req_data_out_ready;
  logic [N_REQ-1:0]      i_req_force_done;
  logic [ADDR_W-1:0]     o_req_addr;
  logic [N_REQ-1:0]      o_req_rd_en;
  logic [31:0]           o_req_data_out;
  logic [N_REQ-1:0]      o_req_data_out_valid;
  logic [N_REQ-1:0]      o_req_force_done_ack;
  logic [N_REQ-1:0]      o_req_pending;

  // Arbiter status
  logic                  o_busy;
  logic [OWN_W-1:0]      o_owner;

  // Hash core side
  logic                  o_hash_start;
  logic [31:0]           o_hash_data_in;
  logic [ADDR_W-1:0]     i_hash_addr;
  logic                  i_hash_rd_en;
  logic [31:0]           i_hash_data_out;
  logic                  i_hash_data_out_valid;
  logic                  o_hash_data_out_ready;
  logic [31:0]           o_hash_input_length;
  logic [31:0]           o_hash_output_length;
  logic                  o_hash_force_done;
  logic                  i_hash_force_done_ack;

  // Arbiter view
  modport slave (
    input  i_req_start, i_req_data_in, i_req_input_length, i_req_output_length,
    input  i_req_data_out_ready, i_req_force_done,
    output o_req_addr, o_req_rd_en, o_req_data_out, o_req_data_out_valid,
    output o_req_force_done_ack, o_req_pending, o_busy, o_owner,
    output o_hash_start, o_hash_data_in,
    input  i_hash_addr, i_hash_rd_en, i_hash_data_out, i_hash_data_out_valid,
    output o_hash_data_out_ready, o_hash_input_length, o_hash_output_length,
    output o_hash_force_done,
    input  i_hash_force_done_ack
  );

  // Requesters plus core view
  modport master (
    output i_req_start, i_req_data_in, i_req_input_length, i_req_output_length,
    output i_req_data_out_ready, i_req_force_done,
    input  o_req_addr, o_req_rd_en, o_req_data_out, o_req_data_out_valid,
    input  o_req_force_done_ack, o_req_pending, o_busy, o_owner,
    input  o_hash_start, o_hash_data_in,
    output i_hash_addr, i_hash_rd_en, i_hash_data_out, i_hash_data_out_valid,
    input  o_hash_data_out_ready, o_hash_input_length, o_hash_output_length,
    input  o_hash_force_done,
    output i_hash_force_done_ack
  );

endinterface

// File: rtl/hash_req_arbiter.sv
// rtl/hash_req_arbiter.sv - round-robin arbiter sharing one SHAKE core among N_REQ requesters
module hash_req_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 5,
  parameter int OWN_W  = $clog2(N_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  hash_req_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [OWN_W-1:0]   rr_q, rr_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;

  logic               pick_vld;
  logic [OWN_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   pick_oh;
  logic [N_REQ-1:0]   owner_oh;
  logic [OWN_W-1:0]   next_rr;
  logic               core_held;
  logic               core_run;
  logic               owner_fd;
  logic               release_w;
  logic [ADDR_W-1:0]  addr_w;
  int                 pick_best;
  int                 pick_dist;

  logic [31:0]        data_in_arr  [N_REQ];
  logic [31:0]        in_len_arr   [N_REQ];
  logic [31:0]        out_len_arr  [N_REQ];

  // The core is held from the issue cycle until the owner's force-done is acked
  assign core_held = (state_q != S_IDLE);
  assign core_run  = (state_q == S_RUN);

  // Owner force-done only reaches the core once it is actually running the owner's job
  assign owner_fd  = core_run & bus.i_req_force_done[owner_q];
  assign release_w = owner_fd & bus.i_hash_force_done_ack;

  // Pointer moves just past the releasing owner so it gets lowest priority next round
  assign next_rr = (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Rotating search: nearest pending requester at or after rr_q, wrapping
  always_comb begin
    pick_vld  = 1'b0;
    pick_idx  = '0;
    pick_best = N_REQ;
    pick_dist = 0;
    for (int j = 0; j < N_REQ; j++) begin
      pick_dist = (j >= int'(rr_q)) ? (j - int'(rr_q)) : (j + N_REQ - int'(rr_q));
      if (pending_q[j] && (pick_dist < pick_best)) begin
        pick_best = pick_dist;
        pick_vld  = 1'b1;
        pick_idx  = OWN_W'(j);
      end
    end
  end

  // One-hot decode of the search winner and of the registered owner
  always_comb begin
    pick_oh  = '0;
    owner_oh = '0;
    for (int j = 0; j < N_REQ; j++) begin
      pick_oh[j]  = (pick_idx == OWN_W'(j));
      owner_oh[j] = (owner_q == OWN_W'(j));
    end
  end

  // Split the flat per-requester buses into words indexed by requester
  always_comb begin
    for (int j = 0; j < N_REQ; j++) begin
      data_in_arr[j] = bus.i_req_data_in[32*j +: 32];
      in_len_arr[j]  = bus.i_req_input_length[32*j +: 32];
      out_len_arr[j] = bus.i_req_output_length[32*j +: 32];
    end
  end

  // Next-state: queue starts, grant from idle, one issue cycle, release on acked force-done
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    // A start on an already-pending bit simply ORs in and is absorbed
    pending_d = pending_q | bus.i_req_start;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          owner_d   = pick_idx;
          pending_d = pending_d & ~pick_oh;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (release_w) begin
          rr_d    = next_rr;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    start_d = (state_d == S_ISSUE);
    busy_d  = (state_d != S_IDLE);
  end

  // State, queue, pointer and registered status outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      rr_q      <= '0;
      owner_q   <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
    end
  end

  assign addr_w = bus.i_hash_addr;

  // Broadcast paths: only the owner's strobe bit ever qualifies them
  assign bus.o_req_addr           = addr_w;
  assign bus.o_req_data_out       = bus.i_hash_data_out;

  // Owner-only strobes; non-owner bits are held at zero
  assign bus.o_req_rd_en          = owner_oh & {N_REQ{core_held & bus.i_hash_rd_en}};
  assign bus.o_req_data_out_valid = owner_oh & {N_REQ{core_run & bus.i_hash_data_out_valid}};
  assign bus.o_req_force_done_ack = owner_oh & {N_REQ{release_w}};
  assign bus.o_req_pending        = pending_q;

  assign bus.o_busy               = busy_q;
  assign bus.o_owner              = owner_q;
  assign bus.o_hash_start         = start_q;

  // Job parameters follow the registered owner in every state
  assign bus.o_hash_data_in        = data_in_arr[owner_q];
  assign bus.o_hash_input_length   = in_len_arr[owner_q];
  assign bus.o_hash_output_length  = out_len_arr[owner_q];
  assign bus.o_hash_data_out_ready = core_run & bus.i_req_data_out_ready[owner_q];
  assign bus.o_hash_force_done     = owner_fd;

endmodule

// File: doc/hash_req_arbiter.md
# hash_req_arbiter

Round-robin arbiter that shares one SHAKE hash core among N_REQ hash requesters in the SDitH sign datapath, such as the seed sibling-path generator, tree expansion and commitment units. Each requester drives the same start / force-done handshake it would drive into a dedicated core. The arbiter queues start pulses, grants the core to one requester at a time, and routes the core's input-read, output-stream and force-done signals to the current owner only. The grant is released when the core acknowledges the owner's force-done.

## Interface
Parameters:
- N_REQ, 3, number of requesters (2..8)
- ADDR_W, 5, width of the core's input-word read address
- OWN_W, `CLOG2(N_REQ), owner index width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_req_start  in  N_REQ  per-requester one-cycle start pulse
- i_req_data_in  in  32*N_REQ  per-requester hash input word (requester memory q)
- i_req_input_length  in  32*N_REQ  per-requester input length, bits
- i_req_output_length  in  32*N_REQ  per-requester output length, bits
- i_req_data_out_ready  in  N_REQ  per-requester output ready
- i_req_force_done  in  N_REQ  per-requester force-done
- o_req_addr  out  ADDR_W  core read address, broadcast
- o_req_rd_en  out  N_REQ  core read enable, owner bit only
- o_req_data_out  out  32  core output word, broadcast
- o_req_data_out_valid  out  N_REQ  output valid, owner bit only
- o_req_force_done_ack  out  N_REQ  force-done ack, owner bit only
- o_req_pending  out  N_REQ  queued-request flags
- o_busy  out  1  core owned (ISSUE or RUN)
- o_owner  out  OWN_W  current or last owner index
- o_hash_start  out  1  core start
- o_hash_data_in  out  32  owner's i_req_data_in
- i_hash_addr  in  ADDR_W  core input read address
- i_hash_rd_en  in  1  core input read enable
- i_hash_data_out  in  32  core output word
- i_hash_data_out_valid  in  1  core output valid
- o_hash_data_out_ready  out  1  owner's ready while RUN, else 0
- o_hash_input_length  out  32  owner's input length
- o_hash_output_length  out  32  owner's output length
- o_hash_force_done  out  1  owner's force-done while RUN, else 0
- i_hash_force_done_ack  in  1  core force-done ack

## Operation
- pending[r] is set by i_req_start[r] and cleared when r is granted. A start on a bit that is already pending is absorbed; the bench sees no second operation.
- Round-robin pointer rr. Grant goes to the first pending index at or after rr, wrapping modulo N_REQ. After a release, rr = owner+1 (wraps to 0 at N_REQ).
- S_IDLE: if any pending bit is set, register owner, clear pending[owner], go to S_ISSUE.
- S_ISSUE: o_hash_start = 1 for exactly one cycle, then go to S_RUN.
- S_RUN: core signals are routed to/from owner. When o_hash_force_done and i_hash_force_done_ack are both high, pulse o_req_force_done_ack[owner], update rr, go to S_IDLE.
- o_hash_data_in and the two length outputs are a combinational mux on the registered owner in all states. o_req_rd_en[owner] = i_hash_rd_en only in S_ISSUE/S_RUN.
- Non-owner valid/ack/rd_en outputs are always 0. Non-owner force_done and ready inputs are ignored. Owner force_done is ignored in S_IDLE/S_ISSUE.
- Owner start during S_RUN (including in the same cycle as the ack) sets its pending bit. It is then arbitrated against the others, with lowest priority.

## Timing
- Reset values: state S_IDLE, pending 0, rr 0, owner 0, o_busy 0, o_hash_start 0, o_hash_force_done 0, all per-requester outputs 0.
- Reset mid-operation aborts the grant and clears the queue. The core must be reset in the same cycle.
- Start pulse at cycle t while idle with nothing pending: pending visible at t+1, o_hash_start high at t+2, S_RUN at t+3.
- Release: ack at cycle a → S_IDLE at a+1. The next o_hash_start is no earlier than a+2.
- o_hash_start, o_busy and o_owner are registered. Data/valid/ready/force-done routing is combinational and adds zero latency.
- Simultaneous starts at the same cycle are granted in rr order, with no starts lost.

## Test plan
- Single requester: i_req_start=3'b001 at t → o_hash_start at t+2; a 16-word output stream reaches o_req_data_out_valid[0] only; force-done/ack → o_req_force_done_ack=3'b001, o_busy=0 next cycle.
- Simultaneous starts 3'b111 with rr=0 → grants in order 0,1,2, three o_hash_start pulses, pending decrementing 110→100→000.
- Owner 0 restarts in the same cycle as its ack while pending=3'b010 → requester 1 is granted next, then 0.
- Input routing: owner 2, i_hash_rd_en with addr 5 → o_req_rd_en=3'b100; o_hash_data_in = requester 2 word; o_hash_input_length = requester 2 length (e.g. 384).
- Non-owner force_done=1 during RUN → o_hash_force_done=0, no ack issued; duplicate start on a pending bit → only one operation.
- i_rst asserted mid-RUN with pending=3'b110 → next cycle all outputs 0, pending 0, rr 0.
